// File: rtl/pipeline_ctrl.sv
// Stall/flush/halt sequencer for the five-stage pipeline: stage-register enables,
// flushes, memory request gating, hit latches and a saturating stall counter.
module pipeline_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_dreq,
    input  logic             mem_halt,
    input  logic             mem_redirect,
    input  logic             ex_load,
    input  logic [4:0]       ex_wsel,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             imem_ren,
    output logic             dmem_req,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic              i_done_reg, i_done_next;
    logic              d_done_reg, d_done_next;
    logic [CNT_W-1:0]  stall_cnt_reg, stall_cnt_next;

    logic run;
    logic i_ok;
    logic d_ok;
    logic advance;
    logic load_use;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg     <= RUN;
            i_done_reg    <= 1'b0;
            d_done_reg    <= 1'b0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            i_done_reg    <= i_done_next;
            d_done_reg    <= d_done_next;
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    assign run      = (state_reg == RUN);
    assign i_ok     = ihit | i_done_reg;
    assign d_ok     = !mem_dreq | dhit | d_done_reg;
    assign advance  = i_ok & d_ok & run;
    assign load_use = ex_load & (ex_wsel != 5'd0) &
                      ((ex_wsel == id_rs) | (id_uses_rt & (ex_wsel == id_rt)));

    always_comb begin
        state_next     = state_reg;
        i_done_next    = i_done_reg;
        d_done_next    = d_done_reg;
        stall_cnt_next = stall_cnt_reg;
        pc_en          = 1'b0;
        if_id_en       = 1'b0;
        id_ex_en       = 1'b0;
        ex_mem_en      = 1'b0;
        wb_en          = 1'b0;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b0;
        ex_mem_flush   = 1'b0;
        imem_ren       = 1'b0;
        dmem_req       = 1'b0;

        case (state_reg)
            RUN: begin
                imem_ren = !i_done_reg;
                dmem_req = mem_dreq & !d_done_reg;

                if (!advance) begin
                    // Remember hits so a skewed partner hit still advances exactly once.
                    i_done_next = i_done_reg | ihit;
                    d_done_next = d_done_reg | (dhit & mem_dreq);
                    if (stall_cnt_reg != {CNT_W{1'b1}})
                        stall_cnt_next = stall_cnt_reg + CNT_W'(1);
                end else begin
                    i_done_next = 1'b0;
                    d_done_next = 1'b0;
                    if (mem_halt)
                        state_next = HALTED;

                    if (mem_redirect) begin
                        pc_en        = 1'b1;
                        if_id_en     = 1'b1;
                        id_ex_en     = 1'b1;
                        ex_mem_en    = 1'b1;
                        wb_en        = 1'b1;
                        if_id_flush  = 1'b1;
                        id_ex_flush  = 1'b1;
                        ex_mem_flush = 1'b1;
                    end else if (load_use) begin
                        // Hold PC and IF/ID, inject a bubble into EX, let older work drain.
                        id_ex_flush = 1'b1;
                        ex_mem_en   = 1'b1;
                        wb_en       = 1'b1;
                    end else begin
                        pc_en     = 1'b1;
                        if_id_en  = 1'b1;
                        id_ex_en  = 1'b1;
                        ex_mem_en = 1'b1;
                        wb_en     = 1'b1;
                    end
                end
            end

            HALTED: begin
                i_done_next = 1'b0;
                d_done_next = 1'b0;
            end

            default: state_next = RUN;
        endcase
    end

    assign halt      = (state_reg == HALTED);
    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: free run, skewed hits, load-use, redirect,
// stall saturation, asynchronous reset mid-wait and HALT.
module tb_pipeline_ctrl;

    localparam int CNT_W = 4;

    logic             CLK;
    logic             nRST;
    logic             ihit, dhit, mem_dreq, mem_halt, mem_redirect;
    logic             ex_load, id_uses_rt;
    logic [4:0]       ex_wsel, id_rs, id_rt;
    logic             pc_en, if_id_en, id_ex_en, ex_mem_en, wb_en;
    logic             if_id_flush, id_ex_flush, ex_mem_flush;
    logic             imem_ren, dmem_req, halt;
    logic [CNT_W-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    pipeline_ctrl #(.CNT_W(CNT_W)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .ihit         (ihit),
        .dhit         (dhit),
        .mem_dreq     (mem_dreq),
        .mem_halt     (mem_halt),
        .mem_redirect (mem_redirect),
        .ex_load      (ex_load),
        .ex_wsel      (ex_wsel),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .id_ex_en     (id_ex_en),
        .ex_mem_en    (ex_mem_en),
        .wb_en        (wb_en),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_flush (ex_mem_flush),
        .imem_ren     (imem_ren),
        .dmem_req     (dmem_req),
        .halt         (halt),
        .stall_cnt    (stall_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // {pc_en, if_id_en, id_ex_en, ex_mem_en, wb_en} and {if_id, id_ex, ex_mem} flushes
    logic [4:0] en;
    logic [2:0] fl;
    assign en = {pc_en, if_id_en, id_ex_en, ex_mem_en, wb_en};
    assign fl = {if_id_flush, id_ex_flush, ex_mem_flush};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Inputs are driven at posedge+1 and outputs sampled at posedge+2.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nRST = 1'b0;
        ihit = 1'b0; dhit = 1'b0; mem_dreq = 1'b1; mem_halt = 1'b0; mem_redirect = 1'b0;
        ex_load = 1'b0; ex_wsel = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
        #2;
        check("rst_en",       32'(en), 32'b00000);
        check("rst_fl",       32'(fl), 32'b000);
        check("rst_imem_ren", 32'(imem_ren), 32'd1);
        check("rst_dmem_req", 32'(dmem_req), 32'd1);
        check("rst_halt",     32'(halt), 32'd0);
        check("rst_stall",    32'(stall_cnt), 32'd0);

        // Free run
        #1;
        nRST = 1'b1; ihit = 1'b1; mem_dreq = 1'b0;
        #1;
        check("free_en0", 32'(en), 32'b11111);
        for (int i = 1; i < 4; i++) begin
            tick();
            check($sformatf("free_en%0d", i), 32'(en), 32'b11111);
            check($sformatf("free_stall%0d", i), 32'(stall_cnt), 32'd0);
        end

        // Skewed hits: ihit in cycle 0, dhit in cycle 3
        tick(); mem_dreq = 1'b1; ihit = 1'b1; dhit = 1'b0; #1;
        check("skew_c0_en", 32'(en), 32'b00000);
        check("skew_c0_imem", 32'(imem_ren), 32'd1);
        check("skew_c0_dreq", 32'(dmem_req), 32'd1);
        tick(); ihit = 1'b0; #1;
        check("skew_c1_en", 32'(en), 32'b00000);
        check("skew_c1_imem", 32'(imem_ren), 32'd0);
        tick(); #1;
        check("skew_c2_en", 32'(en), 32'b00000);
        check("skew_c2_imem", 32'(imem_ren), 32'd0);
        tick(); dhit = 1'b1; #1;
        check("skew_c3_en", 32'(en), 32'b11111);
        check("skew_c3_stall", 32'(stall_cnt), 32'd3);
        tick(); dhit = 1'b0; mem_dreq = 1'b0; ihit = 1'b1; #1;
        check("skew_clear_imem", 32'(imem_ren), 32'd1);
        check("skew_clear_en", 32'(en), 32'b11111);
        check("skew_clear_stall", 32'(stall_cnt), 32'd3);

        // Data hit first, then fetch
        tick(); mem_dreq = 1'b1; dhit = 1'b1; ihit = 1'b0; #1;
        check("dfirst_c0_en", 32'(en), 32'b00000);
        tick(); dhit = 1'b0; ihit = 1'b1; #1;
        check("dfirst_c1_dreq", 32'(dmem_req), 32'd0);
        check("dfirst_c1_en", 32'(en), 32'b11111);
        check("dfirst_c1_stall", 32'(stall_cnt), 32'd4);

        // Load-use on rs
        tick(); mem_dreq = 1'b0; ex_load = 1'b1; ex_wsel = 5'd5; id_rs = 5'd5; #1;
        check("lu_rs_en", 32'(en), 32'b00011);
        check("lu_rs_fl", 32'(fl), 32'b010);
        tick(); ex_load = 1'b0; #1;
        check("lu_after_en", 32'(en), 32'b11111);
        tick(); ex_load = 1'b1; ex_wsel = 5'd0; id_rs = 5'd0; #1;
        check("lu_r0_en", 32'(en), 32'b11111);
        check("lu_r0_fl", 32'(fl), 32'b000);
        tick(); ex_wsel = 5'd7; id_rs = 5'd1; id_rt = 5'd7; id_uses_rt = 1'b1; #1;
        check("lu_rt_en", 32'(en), 32'b00011);
        tick(); id_uses_rt = 1'b0; #1;
        check("lu_rt_unused_en", 32'(en), 32'b11111);
        check("lu_stall", 32'(stall_cnt), 32'd4);

        // Redirect beats load-use
        tick(); id_uses_rt = 1'b1; mem_redirect = 1'b1; #1;
        check("redir_en", 32'(en), 32'b11111);
        check("redir_fl", 32'(fl), 32'b111);
        tick(); ihit = 1'b0; #1;
        check("redir_stalled_en", 32'(en), 32'b00000);
        check("redir_stalled_fl", 32'(fl), 32'b000);

        // Saturation: stall_cnt reaches 5 after the stalled redirect, then 12 more stalls
        tick(); mem_redirect = 1'b0; ex_load = 1'b0; id_uses_rt = 1'b0; #1;
        check("sat_start", 32'(stall_cnt), 32'd5);
        for (int i = 0; i < 12; i++) tick();
        #1;
        check("sat_end", 32'(stall_cnt), 32'd15);

        // Reset mid-wait with i_done latched
        tick(); ihit = 1'b1; mem_dreq = 1'b1; dhit = 1'b0; #1;
        check("rmw_c0_en", 32'(en), 32'b00000);
        tick(); ihit = 1'b0; #1;
        check("rmw_idone_imem", 32'(imem_ren), 32'd0);
        #1; nRST = 1'b0; #1;
        check("rmw_imem", 32'(imem_ren), 32'd1);
        check("rmw_stall", 32'(stall_cnt), 32'd0);
        check("rmw_halt", 32'(halt), 32'd0);
        #1; nRST = 1'b1;
        tick(); #1;
        check("rmw_restart_stall", 32'(stall_cnt), 32'd1);
        tick(); #1;
        check("rmw_restart_stall2", 32'(stall_cnt), 32'd2);

        // Halt
        ihit = 1'b1; dhit = 1'b1; mem_halt = 1'b1; #1;
        check("halt_edge_en", 32'(en), 32'b11111);
        check("halt_edge_halt", 32'(halt), 32'd0);
        tick(); mem_halt = 1'b0; ihit = 1'b0; dhit = 1'b0; #1;
        check("halt_rise", 32'(halt), 32'd1);
        for (int i = 0; i < 10; i++) begin
            ihit = i[0]; dhit = ~i[0]; #1;
            check($sformatf("halted%0d_en", i), 32'(en), 32'b00000);
            check($sformatf("halted%0d_fl", i), 32'(fl), 32'b000);
            check($sformatf("halted%0d_req", i), 32'({imem_ren, dmem_req}), 32'b00);
            check($sformatf("halted%0d_halt", i), 32'(halt), 32'd1);
            check($sformatf("halted%0d_stall", i), 32'(stall_cnt), 32'd2);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        errors++;
        $display("FAIL timeout: got no finish, expected finish before 20000");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
